// File: rtl/period_meter_pkg.sv
// Shared types and defaults for the period meter.
package period_meter_pkg;

    localparam int CNT_W_DEF = 26;
    localparam logic [CNT_W_DEF-1:0] CNT_MAX = '1;

    typedef enum logic {
        IDLE,
        MEAS
    } state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer with a registered previous value and rising-edge pulse.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_sync;
    logic                   s_prev;

    assign s_sync = sync_q[SYNC_STAGES-1];
    assign rise   = s_sync & ~s_prev;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= '0;
            s_prev <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            s_prev <= s_sync;
        end
    end

endmodule

// File: rtl/period_meter.sv
// Measures the period of a slow square wave in clk cycles; results leave
// through a single-entry valid/ready register that drops and flags overruns.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic [CNT_W-1:0] period,
    output logic             overflow,
    output logic             missed,
    output logic             busy
);

    localparam logic [CNT_W-1:0] FULL = '1;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             sat;
    logic             rise;
    logic             done;
    logic             ovf_now;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .rst    (rst),
        .sig_in (sig_in),
        .rise   (rise)
    );

    assign done    = (state == MEAS) && rise;
    // A period of exactly full scale is reported as overflow too.
    assign ovf_now = sat | (cnt == FULL);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            sat        <= 1'b0;
            busy       <= 1'b0;
            meas_valid <= 1'b0;
            period     <= '0;
            overflow   <= 1'b0;
            missed     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise) begin
                        cnt   <= CNT_W'(1);
                        sat   <= 1'b0;
                        state <= MEAS;
                        busy  <= 1'b1;
                    end
                end
                MEAS: begin
                    if (rise) begin
                        cnt <= CNT_W'(1);
                        sat <= 1'b0;
                    end else if (cnt == FULL) begin
                        sat <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // Held result is only replaced once it has been accepted.
            if (done) begin
                if (!meas_valid || meas_ready) begin
                    period     <= cnt;
                    overflow   <= ovf_now;
                    meas_valid <= 1'b1;
                    if (meas_valid) missed <= 1'b0;
                end else begin
                    missed <= 1'b1;
                end
            end else if (meas_valid && meas_ready) begin
                meas_valid <= 1'b0;
                missed     <= 1'b0;
            end
        end
    end

endmodule
